// File: rtl/bottleneck_pkg.sv
// Shared encodings and helpers for the 64-to-16-bit access sequencer.
package bottleneck_pkg;

   typedef enum logic [1:0] {
      SIZ_8  = 2'b00,
      SIZ_16 = 2'b01,
      SIZ_32 = 2'b10,
      SIZ_64 = 2'b11
   } siz_e;

   // ST_TOUT is only reachable when the beat watchdog is built in.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BEAT,
      ST_ACK,
      ST_ERR,
      ST_TOUT
   } state_e;

   typedef struct packed {
      logic [63:0] adr;
      logic [63:0] dat;
      siz_e        siz;
      logic        we;
      logic        sgn;
   } req_t;

   function automatic logic [2:0] beats_for(siz_e s);
      case (s)
         SIZ_64:  return 3'd4;
         SIZ_32:  return 3'd2;
         default: return 3'd1;
      endcase
   endfunction

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] align_mask(siz_e s);
      case (s)
         SIZ_16:  return 3'b001;
         SIZ_32:  return 3'b011;
         SIZ_64:  return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/bottleneck_seq_if.sv
// Bus bundle: CPU-side request/response and the 16-bit slave port.
// m_err_bus_o exists only when BOTTLENECK_SEQ_TIMEOUT_EN is defined.
interface bottleneck_seq_if;
   logic [63:0] m_adr_i;
   logic        m_cyc_i;
   logic        m_stb_i;
   logic        m_we_i;
   logic [1:0]  m_siz_i;
   logic        m_signed_i;
   logic [63:0] m_dat_i;
   logic        m_ack_o;
   logic [63:0] m_dat_o;
   logic        m_err_align_o;
`ifdef BOTTLENECK_SEQ_TIMEOUT_EN
   logic        m_err_bus_o;
`endif
   logic [63:0] s_adr_o;
   logic        s_cyc_o;
   logic        s_stb_o;
   logic        s_we_o;
   logic        s_siz_o;
   logic        s_signed_o;
   logic [15:0] s_dat_o;
   logic        s_ack_i;
   logic [15:0] s_dat_i;

   // master: the surrounding system (CPU requester plus peripheral responder)
   modport master (
      output m_adr_i, m_cyc_i, m_stb_i, m_we_i, m_siz_i, m_signed_i, m_dat_i,
      output s_ack_i, s_dat_i,
      input  m_ack_o, m_dat_o, m_err_align_o,
`ifdef BOTTLENECK_SEQ_TIMEOUT_EN
      input  m_err_bus_o,
`endif
      input  s_adr_o, s_cyc_o, s_stb_o, s_we_o, s_siz_o, s_signed_o, s_dat_o
   );

   // slave: the sequencer itself
   modport slave (
      input  m_adr_i, m_cyc_i, m_stb_i, m_we_i, m_siz_i, m_signed_i, m_dat_i,
      input  s_ack_i, s_dat_i,
      output m_ack_o, m_dat_o, m_err_align_o,
`ifdef BOTTLENECK_SEQ_TIMEOUT_EN
      output m_err_bus_o,
`endif
      output s_adr_o, s_cyc_o, s_stb_o, s_we_o, s_siz_o, s_signed_o, s_dat_o
   );
endinterface

// File: rtl/bottleneck_extend.sv
// Combinational read-data extension from access size to 64 bits.
module bottleneck_extend
   import bottleneck_pkg::*;
(
   input  logic [63:0] acc,
   input  siz_e        siz,
   input  logic        sgn,
   output logic [63:0] dat
);
   always_comb begin
      dat = acc;
      case (siz)
         SIZ_8:   dat = {{56{sgn & acc[7]}},  acc[7:0]};
         SIZ_16:  dat = {{48{sgn & acc[15]}}, acc[15:0]};
         SIZ_32:  dat = {{32{sgn & acc[31]}}, acc[31:0]};
         default: dat = acc;
      endcase
   end
endmodule

// File: rtl/bottleneck_seq.sv
// Splits 8/16/32/64-bit master accesses into little-endian 16-bit slave beats.
// Define BOTTLENECK_SEQ_TIMEOUT_EN to add a per-beat watchdog and m_err_bus_o.
module bottleneck_seq
   import bottleneck_pkg::*;
#(
   parameter int TIMEOUT_W = 8
) (
   input  logic            clk_i,
   input  logic            reset_i,
   bottleneck_seq_if.slave bus
);
   if (TIMEOUT_W < 2) begin : g_bad_tw
      $error("TIMEOUT_W must be at least 2");
   end

   state_e      state_q, state_d;
   req_t        req_q;
   logic [1:0]  k_q;
   logic [63:0] acc_q;
   logic [63:0] ext_dat;
   logic        start, misaligned, last, in_beat;

   assign start      = bus.m_cyc_i & bus.m_stb_i;
   assign misaligned = |(bus.m_adr_i[2:0] & align_mask(siz_e'(bus.m_siz_i)));
   assign last       = (k_q == 2'(beats_for(req_q.siz) - 3'd1));
   assign in_beat    = (state_q == ST_BEAT);

`ifdef BOTTLENECK_SEQ_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] cnt_q, cnt_inc;
   logic                 tout;

   assign cnt_inc = cnt_q + TIMEOUT_W'(1);
   assign tout    = &cnt_inc;

   always_ff @(posedge clk_i) begin
      if (!reset_i || !in_beat || bus.s_ack_i) cnt_q <= '0;
      else                                     cnt_q <= cnt_inc;
   end

   assign bus.m_err_bus_o = (state_q == ST_TOUT);
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = misaligned ? ST_ERR : ST_BEAT;
         ST_BEAT: begin
            // Master abort wins over a coincident slave ack.
            if (!bus.m_cyc_i)                state_d = ST_IDLE;
            else if (bus.s_ack_i && last)    state_d = ST_ACK;
`ifdef BOTTLENECK_SEQ_TIMEOUT_EN
            else if (!bus.s_ack_i && tout)   state_d = ST_TOUT;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         k_q     <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: if (start && !misaligned) begin
               req_q.adr <= bus.m_adr_i;
               req_q.dat <= bus.m_dat_i;
               req_q.siz <= siz_e'(bus.m_siz_i);
               req_q.we  <= bus.m_we_i;
               req_q.sgn <= bus.m_signed_i;
               k_q       <= '0;
               acc_q     <= '0;
            end
            ST_BEAT: if (bus.m_cyc_i && bus.s_ack_i) begin
               acc_q[{k_q, 4'b0000} +: 16] <= bus.s_dat_i;
               if (!last) k_q <= k_q + 2'd1;
            end
            default: ;
         endcase
      end
   end

   bottleneck_extend u_extend (
      .acc (acc_q),
      .siz (req_q.siz),
      .sgn (req_q.sgn),
      .dat (ext_dat)
   );

   assign bus.m_ack_o       = (state_q == ST_ACK);
   assign bus.m_dat_o       = (state_q == ST_ACK && !req_q.we) ? ext_dat : '0;
   assign bus.m_err_align_o = (state_q == ST_ERR);

   // Byte beats keep the unmodified address; wider accesses step by halfwords.
   assign bus.s_cyc_o    = in_beat;
   assign bus.s_stb_o    = in_beat;
   assign bus.s_we_o     = in_beat & req_q.we;
   assign bus.s_siz_o    = in_beat & (req_q.siz != SIZ_8);
   assign bus.s_signed_o = req_q.sgn;
   assign bus.s_adr_o    = in_beat ? req_q.adr + {61'd0, k_q, 1'b0} : '0;
   assign bus.s_dat_o    = !in_beat             ? '0 :
                           (req_q.siz == SIZ_8) ? {8'h00, req_q.dat[7:0]} :
                                                  req_q.dat[{k_q, 4'b0000} +: 16];
endmodule

// File: tb/tb_bottleneck_seq.sv
// Randomized bench for bottleneck_seq: byte-addressed slave memory, stray acks,
// wait states, and a byte-level reference model of each master access.
module tb_bottleneck_seq;
   import bottleneck_pkg::*;

   logic clk_i   = 1'b0;
   logic reset_i = 1'b0;
   always #5 clk_i = ~clk_i;

   bottleneck_seq_if bus();

   bottleneck_seq #(.TIMEOUT_W(4)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (bus)
   );

   typedef struct {
      logic [63:0] adr;
      logic        we;
      logic        siz;
      logic        sgn;
      logic [15:0] dat;
   } beat_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  mem8 [512];
   logic [7:0]  ref8 [512];
   beat_t       blog [$];
   int          waits = 0;
   int          wcnt  = 0;
   bit          no_ack = 0;
   bit          stray_en = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic set_mem(input int a, input logic [7:0] v);
      mem8[a] = v;
      ref8[a] = v;
   endtask

   function automatic logic [63:0] out_vec();
      return {bus.m_ack_o, bus.m_err_align_o, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o,
              bus.s_siz_o, bus.s_signed_o, 57'd0} | bus.m_dat_o | bus.s_adr_o | 64'(bus.s_dat_o);
   endfunction

   // Peripheral model: acks after `waits` idle cycles per beat, random acks when not selected.
   initial begin
      int a;
      bus.s_ack_i = 1'b0;
      bus.s_dat_i = '0;
      forever begin
         @(negedge clk_i);
         if (bus.s_cyc_o && bus.s_stb_o) begin
            if (wcnt == 0 && !no_ack) begin
               a = int'(bus.s_adr_o[8:0]);
               blog.push_back('{bus.s_adr_o, bus.s_we_o, bus.s_siz_o, bus.s_signed_o, bus.s_dat_o});
               bus.s_ack_i = 1'b1;
               if (bus.s_siz_o) begin
                  bus.s_dat_i = {mem8[(a + 1) & 511], mem8[a]};
                  if (bus.s_we_o) begin
                     mem8[a]             = bus.s_dat_o[7:0];
                     mem8[(a + 1) & 511] = bus.s_dat_o[15:8];
                  end
               end else begin
                  bus.s_dat_i = {8'($urandom), mem8[a]};
                  if (bus.s_we_o) mem8[a] = bus.s_dat_o[7:0];
               end
               wcnt = waits;
            end else begin
               bus.s_ack_i = 1'b0;
               bus.s_dat_i = 16'($urandom);
               if (wcnt > 0) wcnt--;
            end
         end else begin
            bus.s_ack_i = stray_en && ($urandom_range(3) == 0);
            bus.s_dat_i = 16'($urandom);
            wcnt = waits;
         end
      end
   end

   task automatic do_req(input logic [63:0] adr, input logic [1:0] siz, input logic we,
                         input logic sgn, input logic [63:0] dat, input int w,
                         output logic [63:0] rd);
      int          nb, b, a, cyc, sh, nbad;
      bit          mis, done, got_ack, got_err, quiet_bad;
      logic [63:0] exp_d;
      nb    = 1 << siz;
      b     = (nb + 1) / 2;
      a     = int'(adr[8:0]);
      mis   = (adr % 64'(nb)) != 0;
      exp_d = '0;
      if (!mis && !we) begin
         for (int i = 0; i < nb; i++) exp_d |= 64'(ref8[a + i]) << (8 * i);
         if (sgn) begin
            sh    = 64 - 8 * nb;
            exp_d = 64'($signed(exp_d << sh) >>> sh);
         end
      end
      if (!mis && we)
         for (int i = 0; i < nb; i++) ref8[a + i] = dat[8 * i +: 8];

      @(negedge clk_i); #1;
      waits = w;
      wcnt  = w;
      blog.delete();
      bus.m_adr_i = adr; bus.m_siz_i = siz; bus.m_we_i = we; bus.m_signed_i = sgn;
      bus.m_dat_i = dat; bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1;
      @(posedge clk_i);
      cyc = 0; done = 0; got_ack = 0; got_err = 0; quiet_bad = 0; rd = '0;
      while (!done && cyc < 200) begin
         @(negedge clk_i); #1;
         cyc++;
         if (mis && bus.s_cyc_o) quiet_bad = 1;
         if (bus.m_ack_o || bus.m_err_align_o) begin
            done    = 1;
            got_ack = bus.m_ack_o;
            got_err = bus.m_err_align_o;
            rd      = bus.m_dat_o;
            bus.m_cyc_i = 1'b0;
            bus.m_stb_i = 1'b0;
         end else if (bus.m_dat_o != '0) quiet_bad = 1;
      end
      bus.m_cyc_i = 1'b0;
      bus.m_stb_i = 1'b0;
      check("done", 64'(done), 64'd1);
      check("latency", 64'(cyc), mis ? 64'd1 : 64'(b * (1 + w) + 1));
      check("ack", 64'(got_ack), 64'(!mis));
      check("err_align", 64'(got_err), 64'(mis));
      check("m_dat", rd, exp_d);
      check("quiet", 64'(quiet_bad), 64'd0);
      check("nbeats", 64'(blog.size()), mis ? 64'd0 : 64'(b));
      for (int i = 0; i < blog.size() && i < b; i++) begin
         check("beat_adr", blog[i].adr, adr + 64'(2 * i));
         check("beat_ctl", {61'd0, blog[i].we, blog[i].siz, blog[i].sgn},
               {61'd0, we, siz != 2'b00, sgn});
         if (we)
            check("beat_wdat", 64'(blog[i].dat),
                  siz == 2'b00 ? {56'd0, dat[7:0]} : 64'(dat[16 * i +: 16]));
      end
      if (we && !mis) begin
         nbad = 0;
         for (int i = 0; i < 512; i++) if (mem8[i] !== ref8[i]) nbad++;
         check("wmem", 64'(nbad), 64'd0);
      end
   endtask

   initial begin
      logic [63:0] rd, adr;
      logic [1:0]  siz;
      int          cyc;
      bit          seen;
      for (int i = 0; i < 512; i++) set_mem(i, 8'($urandom));
      bus.m_adr_i = '0; bus.m_cyc_i = 0; bus.m_stb_i = 0; bus.m_we_i = 0;
      bus.m_siz_i = '0; bus.m_signed_i = 0; bus.m_dat_i = '0;

      repeat (3) @(posedge clk_i);
      @(negedge clk_i); #1;
      check("reset_outs", out_vec(), 64'd0);
      reset_i  = 1'b1;
      stray_en = 1;

      // 16b signed read, zero wait
      set_mem(0, 8'h01); set_mem(1, 8'h80);
      do_req(64'h1000, 2'b01, 0, 1, '0, 0, rd);
      check("tp_rd16s", rd, 64'hFFFF_FFFF_FFFF_8001);

      // 64b unsigned read
      set_mem(0, 8'h11); set_mem(1, 8'h11); set_mem(2, 8'h22); set_mem(3, 8'h22);
      set_mem(4, 8'h33); set_mem(5, 8'h33); set_mem(6, 8'h44); set_mem(7, 8'h44);
      do_req(64'h2000, 2'b11, 0, 0, '0, 0, rd);
      check("tp_rd64", rd, 64'h4444_3333_2222_1111);

      // 32b write with two wait states per beat
      do_req(64'h3004, 2'b10, 1, 0, 64'hDEAD_BEEF, 2, rd);

      // misaligned 64b access
      do_req(64'h4004, 2'b11, 0, 0, '0, 0, rd);

      // abort after the first beat of a 32b read
      @(negedge clk_i); #1;
      waits = 1; wcnt = 1; blog.delete();
      bus.m_adr_i = 64'h0100; bus.m_siz_i = 2'b10; bus.m_we_i = 0; bus.m_signed_i = 0;
      bus.m_cyc_i = 1; bus.m_stb_i = 1;
      @(posedge clk_i);
      cyc = 0;
      while (blog.size() == 0 && cyc < 20) begin @(negedge clk_i); #1; cyc++; end
      check("abort_first_beat", 64'(blog.size()), 64'd1);
      @(negedge clk_i); #1;
      bus.m_cyc_i = 0; bus.m_stb_i = 0;
      @(negedge clk_i); #1;
      check("abort_scyc", {62'd0, bus.s_cyc_o, bus.s_stb_o}, 64'd0);
      seen = 0;
      repeat (5) begin
         if (bus.m_ack_o) seen = 1;
         @(negedge clk_i); #1;
      end
      check("abort_noack", 64'(seen), 64'd0);
      check("abort_nbeats", 64'(blog.size()), 64'd1);

      // 8b signed read after the abort
      set_mem(9'h011, 8'h80);
      do_req(64'h0011, 2'b00, 0, 1, '0, 0, rd);
      check("tp_rd8s", rd, 64'hFFFF_FFFF_FFFF_FF80);

      // reset in the middle of a beat
      @(negedge clk_i); #1;
      waits = 3; wcnt = 3;
      bus.m_adr_i = 64'h0040; bus.m_siz_i = 2'b11; bus.m_we_i = 0; bus.m_signed_i = 1;
      bus.m_cyc_i = 1; bus.m_stb_i = 1;
      repeat (2) @(negedge clk_i);
      #1;
      reset_i = 0; bus.m_cyc_i = 0; bus.m_stb_i = 0;
      @(negedge clk_i); #1;
      check("midreset_outs", out_vec(), 64'd0);
      reset_i = 1;
      seen = 0;
      repeat (8) begin
         @(negedge clk_i); #1;
         if (bus.m_ack_o || bus.m_err_align_o || bus.s_cyc_o) seen = 1;
      end
      check("midreset_quiet", 64'(seen), 64'd0);

`ifdef BOTTLENECK_SEQ_TIMEOUT_EN
      // slave never answers: watchdog fires 15 cycles after beat start
      @(negedge clk_i); #1;
      no_ack = 1; waits = 0; wcnt = 0;
      bus.m_adr_i = 64'h0020; bus.m_siz_i = 2'b01; bus.m_we_i = 0;
      bus.m_cyc_i = 1; bus.m_stb_i = 1;
      @(posedge clk_i);
      cyc = 0; seen = 0;
      while (!bus.m_err_bus_o && cyc < 40) begin
         @(negedge clk_i); #1; cyc++;
         if (bus.m_ack_o) seen = 1;
      end
      bus.m_cyc_i = 0; bus.m_stb_i = 0;
      check("tout_cycle", 64'(cyc), 64'd16);
      check("tout_noack", 64'(seen), 64'd0);
      check("tout_scyc", 64'(bus.s_cyc_o), 64'd0);
      @(negedge clk_i); #1;
      check("tout_pulse", 64'(bus.m_err_bus_o), 64'd0);
      no_ack = 0;
`endif

      // randomized accesses
      for (int t = 0; t < 40; t++) begin
         siz = 2'($urandom);
         adr = {$urandom, $urandom};
         if ($urandom_range(1) == 1) adr = adr & ~(64'(1 << siz) - 64'd1);
         do_req(adr, siz, 1'($urandom), 1'($urandom), {$urandom, $urandom},
                int'($urandom_range(2)), rd);
         repeat ($urandom_range(2)) @(negedge clk_i);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=stuck exp=finish");
      $fatal(1, "simulation time limit");
   end
endmodule
